fetch_queue: RTL

- Decoupling buffer between the instruction fetch stage and the decode stage.
- Captures {pc, instruction} pairs produced by fetch and presents them in order to decode through a valid/ready handshake.
- Absorbs decode stalls without stalling the PC, and discards all buffered work on a branch redirect (flush).
- Detects the halt opcode and stops accepting fetches until flush or reset.

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fq_ptr.sv | 25 ++
 rtl/fetch_queue.sv | 106 ++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue: word width, halt opcode and entry layout.
package fetch_queue_pkg;

  localparam int WORD_W = 16;
  localparam logic [3:0] DEF_HLT_OPCODE = 4'b1111;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } entry_t;

endpackage

// File: rtl/fq_ptr.sv
// Modulo-DEPTH pointer with increment enable and synchronous clear; clear wins over increment.
module fq_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  input  logic                     clr,
  output logic [$clog2(DEPTH)-1:0] ptr
);

  localparam int PW = $clog2(DEPTH);

  // DEPTH is a power of two, so natural overflow gives the modulo wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// In-order fetch->decode buffer with flush and sticky halt detection.
// Optional zero-latency bypass when empty: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int         DEPTH      = 4,
  parameter logic [3:0] HLT_OPCODE = DEF_HLT_OPCODE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_W-1:0]        in_pc,
  input  logic [WORD_W-1:0]        in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W-1:0]        out_pc,
  output logic [WORD_W-1:0]        out_instr,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            empty;
  logic            bypass;
  logic            push;
  logic            write;
  logic            pop;

  assign empty    = (count == '0);
  assign in_ready = (count < CW'(DEPTH)) && !halted;

`ifdef FETCH_QUEUE_BYPASS_EN
  // A halted queue accepts nothing, so it must not present a bypassed entry either.
  assign bypass = empty && in_valid && !flush && !halted;
`else
  assign bypass = 1'b0;
`endif

  assign push  = in_valid && in_ready && !flush;
  assign write = push && !(bypass && out_ready);
  assign pop   = !empty && out_ready && !flush;

  always_comb begin
    head = '0;
    if (bypass) begin
      head = '{pc: in_pc, instr: in_instr};
    end else if (!empty) begin
      head = mem[rd_ptr];
    end
  end

  assign out_valid = !empty || bypass;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  fq_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (write),
    .clr (flush),
    .ptr (wr_ptr)
  );

  fq_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .clr (flush),
    .ptr (rd_ptr)
  );

  // Storage has no reset; contents are only observed through count-qualified reads.
  always_ff @(posedge clk) begin
    if (write) begin
      mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      halted <= 1'b0;
    end else if (flush) begin
      count  <= '0;
      halted <= 1'b0;
    end else begin
      case ({write, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && (in_instr[15:12] == HLT_OPCODE)) begin
        halted <= 1'b1;
      end
    end
  end

endmodule
